// File: rtl/cbp_serial_subtractor_if.sv
// Start/done handshake and result bus for the serial carry-bypass subtractor.
interface cbp_serial_subtractor_if #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int CW   = $clog2(NBLK + 1);

    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Diff;
    logic             Bout;
    logic             Ovf;
    logic [CW-1:0]    BypassCnt;

    modport master (
        output start, A, B, Bin,
        input  ready, busy, done, Diff, Bout, Ovf, BypassCnt
    );

    modport slave (
        input  start, A, B, Bin,
        output ready, busy, done, Diff, Bout, Ovf, BypassCnt
    );
endinterface

// File: rtl/cbp_serial_subtractor.sv
// Multi-cycle subtractor: Diff = A - B - Bin, one carry-bypass block per cycle,
// computed as A + ~B + ~Bin with the carry register holding ~borrow.
module cbp_serial_subtractor #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input logic                   clk,
    input logic                   rst,
    cbp_serial_subtractor_if.slave bus
);
    localparam int NBLK = WIDTH / BLOCK;
    localparam int CW   = $clog2(NBLK + 1);
    localparam int IW   = $clog2(NBLK);

    generate
        if ((WIDTH % BLOCK) != 0 || NBLK < 2) begin : g_bad_params
            $error("cbp_serial_subtractor: WIDTH must be a multiple of BLOCK with WIDTH/BLOCK >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] a_q, b_q;
    logic             cy_q;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] diff_q;
    logic [CW-1:0]    cnt_q;
    logic             bout_q, ovf_q;

    logic [BLOCK-1:0] a_blk, nb_blk, blk_sum;
    logic             cy, ripple_cout, bypass, blk_cout;
    logic             last, accept;

    assign last   = (idx == IW'(NBLK - 1));
    assign accept = bus.start && (state == IDLE || state == DONE);

    // Block adder: ripple sum for the bits, bypass mux only picks the carry source.
    always_comb begin
        a_blk   = a_q[idx*BLOCK +: BLOCK];
        nb_blk  = ~b_q[idx*BLOCK +: BLOCK];
        cy      = cy_q;
        blk_sum = '0;
        for (int i = 0; i < BLOCK; i++) begin
            blk_sum[i] = a_blk[i] ^ nb_blk[i] ^ cy;
            cy         = (a_blk[i] & nb_blk[i]) | ((a_blk[i] ^ nb_blk[i]) & cy);
        end
        ripple_cout = cy;
        bypass      = &(a_blk ^ nb_blk);
        blk_cout    = bypass ? cy_q : ripple_cout;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (bus.start) state_n = RUN;
            RUN:     if (last) state_n = DONE;
            DONE:    state_n = bus.start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            diff_q <= '0;
            cnt_q  <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx    <= '0;
        end else if (accept) begin
            a_q    <= bus.A;
            b_q    <= bus.B;
            cy_q   <= ~bus.Bin;
            idx    <= '0;
            diff_q <= '0;
            cnt_q  <= '0;
            bout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (state == RUN) begin
            diff_q[idx*BLOCK +: BLOCK] <= blk_sum;
            cy_q <= blk_cout;
            idx  <= idx + IW'(1);
            if (bypass) cnt_q <= cnt_q + CW'(1);
            // Final block: carry out is ~borrow, MSB of this block is the result sign.
            if (last) begin
                bout_q <= ~blk_cout;
                ovf_q  <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (blk_sum[BLOCK-1] != a_q[WIDTH-1]);
            end
        end
    end

    assign bus.ready     = (state == IDLE) || (state == DONE);
    assign bus.busy      = (state == RUN);
    assign bus.done      = (state == DONE);
    assign bus.Diff      = diff_q;
    assign bus.Bout      = bout_q;
    assign bus.Ovf       = ovf_q;
    assign bus.BypassCnt = cnt_q;
endmodule
